// File: rtl/gv_pkg.sv
// Shared definitions for the score UART transmit path.
//   tx_state_t : transmit FSM states
//   FRAME_HDR  : first byte of every result frame
//   FRAME_LEN  : number of bytes per result frame
package gv_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RDY  = 3'd1,
    STROBE    = 3'd2,
    WAIT_BUSY = 3'd3,
    FINISH    = 3'd4
  } tx_state_t;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         FRAME_LEN = 6;

endpackage

// File: rtl/score_frame_mux.sv
// Combinational frame byte selector for the score result frame.
// Ports:
//   mode_i    : latched game mode (3 bits)
//   hits_i    : latched hit count
//   misses_i  : latched miss count
//   score_i   : latched score
//   idx_i     : byte index within the frame (0..5)
//   byte_o    : frame byte at idx_i (header, fields, then XOR checksum)
module score_frame_mux
  import gv_pkg::*;
(
  input  logic [2:0] mode_i,
  input  logic [7:0] hits_i,
  input  logic [7:0] misses_i,
  input  logic [7:0] score_i,
  input  logic [2:0] idx_i,
  output logic [7:0] byte_o
);

  logic [7:0] mode_byte;
  logic [7:0] checksum;

  assign mode_byte = {5'b0, mode_i};
  // Plain 8-bit XOR over the payload bytes, header excluded.
  assign checksum  = mode_byte ^ hits_i ^ misses_i ^ score_i;

  always_comb begin
    byte_o = 8'h00;
    case (idx_i)
      3'd0:    byte_o = FRAME_HDR;
      3'd1:    byte_o = mode_byte;
      3'd2:    byte_o = hits_i;
      3'd3:    byte_o = misses_i;
      3'd4:    byte_o = score_i;
      3'd5:    byte_o = checksum;
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/score_uart_tx.sv
// Sends the end-of-song result frame to the host over the byte-wide UART TX
// port. A start pulse in IDLE latches mode/hits/misses/score; the block then
// sends A5, mode, hits, misses, score, checksum, each with a txclk strobe.
// Ports:
//   clk        : system clock
//   n_rst      : synchronous active-low reset
//   start      : one-cycle frame request (ignored unless idle)
//   mode       : game mode, latched on start
//   num_hits   : hit count, latched on start
//   num_misses : miss count, latched on start
//   score      : score, latched on start
//   txready    : UART can accept a byte when high
//   txdata     : byte being sent
//   txclk      : byte strobe, high for STROBE_LEN cycles per byte
//   busy       : high from the cycle after an accepted start until done
//   done       : one-cycle pulse after the last byte is accepted
module score_uart_tx
  import gv_pkg::*;
#(
  parameter int STROBE_LEN   = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [2:0] mode,
  input  logic [7:0] num_hits,
  input  logic [7:0] num_misses,
  input  logic [7:0] score,
  input  logic       txready,
  output logic [7:0] txdata,
  output logic       txclk,
  output logic       busy,
  output logic       done
);

  localparam int STB_W = $clog2(STROBE_LEN + 1);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

  tx_state_t        state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       mode_q, mode_d;
  logic [7:0]       hits_q, hits_d;
  logic [7:0]       misses_q, misses_d;
  logic [7:0]       score_q, score_d;
  logic [7:0]       txdata_q, txdata_d;
  logic             txclk_q, txclk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [7:0]       frame_byte;

  score_frame_mux u_mux (
    .mode_i   (mode_q),
    .hits_i   (hits_q),
    .misses_i (misses_q),
    .score_i  (score_q),
    .idx_i    (idx_q),
    .byte_o   (frame_byte)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    hits_d    = hits_q;
    misses_d  = misses_q;
    score_d   = score_q;
    txdata_d  = txdata_q;
    txclk_d   = txclk_q;
    busy_d    = busy_q;
    done_d    = done_q;
    stb_cnt_d = stb_cnt_q;
    tmo_cnt_d = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = mode;
          hits_d   = num_hits;
          misses_d = num_misses;
          score_d  = score;
          idx_d    = 3'd0;
          busy_d   = 1'b1;
          state_d  = WAIT_RDY;
        end
      end

      WAIT_RDY: begin
        // Loaded while waiting so the byte is already on txdata the same
        // edge txclk rises, and stays frozen for the whole strobe.
        txdata_d = frame_byte;
        if (txready) begin
          txclk_d   = 1'b1;
          stb_cnt_d = '0;
          state_d   = STROBE;
        end
      end

      STROBE: begin
        // txready is deliberately not looked at here.
        if (stb_cnt_q == STB_W'(STROBE_LEN - 1)) begin
          txclk_d   = 1'b0;
          tmo_cnt_d = '0;
          state_d   = WAIT_BUSY;
        end else begin
          stb_cnt_d = stb_cnt_q + 1'b1;
        end
      end

      WAIT_BUSY: begin
        // Either the UART signals it took the byte by dropping txready, or
        // after BUSY_TIMEOUT cycles here we assume it did.
        if (!txready || (tmo_cnt_q >= TMO_W'(BUSY_TIMEOUT - 1))) begin
          if (idx_q == 3'(FRAME_LEN - 1)) begin
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = WAIT_RDY;
          end
        end else if (tmo_cnt_q != TMO_W'(BUSY_TIMEOUT)) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      FINISH: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      mode_q    <= 3'd0;
      hits_q    <= 8'h00;
      misses_q  <= 8'h00;
      score_q   <= 8'h00;
      txdata_q  <= 8'h00;
      txclk_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stb_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      hits_q    <= hits_d;
      misses_q  <= misses_d;
      score_q   <= score_d;
      txdata_q  <= txdata_d;
      txclk_q   <= txclk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      stb_cnt_q <= stb_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign txdata = txdata_q;
  assign txclk  = txclk_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_score_uart_tx.sv
module tb_score_uart_tx;

  localparam int STROBE_LEN   = 2;
  localparam int BUSY_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] num_hits = 8'h00;
  logic [7:0] num_misses = 8'h00;
  logic [7:0] score = 8'h00;
  logic       txready = 1'b0;
  logic [7:0] txdata;
  logic       txclk;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  score_uart_tx #(
    .STROBE_LEN   (STROBE_LEN),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .mode       (mode),
    .num_hits   (num_hits),
    .num_misses (num_misses),
    .score      (score),
    .txready    (txready),
    .txdata     (txdata),
    .txclk      (txclk),
    .busy       (busy),
    .done       (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int  done_cnt  = 0;
  int  strobes   = 0;
  int  exp_gap   = 0;   // expected cycles between strobe rises, 0 = unchecked
  bit  ready_en  = 1'b0;
  bit  auto_drop = 1'b1;
  int  frames    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  // UART model: txready follows ready_en, dropping for one cycle after
  // each strobe falls when auto_drop is set.
  initial begin : responder
    bit prev;
    bit drop;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      drop    = auto_drop && prev && !txclk;
      prev    = txclk;
      txready = ready_en && !drop;
    end
  end

  // Monitor: pops the expected byte on every txclk rise, checks strobe
  // width and spacing, and counts done pulses.
  initial begin : monitor
    bit         prev;
    int         hi;
    int         last_rise;
    logic [7:0] e;
    prev = 1'b0;
    hi = 0;
    last_rise = -1;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        exp_q.delete();
        hi = 0;
        last_rise = -1;
        prev = 1'b0;
      end else begin
        if (txclk && !prev) begin
          strobes++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_strobe: got byte 0x%0h, none expected", txdata);
          end else begin
            e = exp_q.pop_front();
            chk("txdata", int'(txdata), int'(e));
          end
          if (exp_gap != 0 && last_rise >= 0)
            chk("strobe_gap", cyc - last_rise, exp_gap);
          last_rise = cyc;
          hi = 1;
        end else if (txclk) begin
          hi++;
        end else if (prev) begin
          chk("strobe_len", hi, STROBE_LEN);
        end
        if (done) begin
          done_cnt++;
          chk("bytes_left_at_done", exp_q.size(), 0);
        end
        if (!busy && !done) last_rise = -1;
        prev = txclk;
      end
    end
  end

  task automatic send(input logic [2:0] m, input logic [7:0] h, input logic [7:0] mi,
                      input logic [7:0] s, input logic [7:0] ck);
    @(negedge clk);
    mode = m; num_hits = h; num_misses = mi; score = s;
    start = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back({5'b0, m});
    exp_q.push_back(h);
    exp_q.push_back(mi);
    exp_q.push_back(s);
    exp_q.push_back(ck);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_frame(input int limit);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      bound_fail("done_wait");
    end else begin
      frames++;
      @(negedge clk);
      chk("busy_low_after_done", int'(busy), 0);
      chk("done_single_pulse", int'(done), 0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_strobes(input int target, input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (strobes >= target) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) bound_fail("strobe_wait");
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s0;
    n_rst = 1'b0;
    ready_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txclk", int'(txclk), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_txdata", int'(txdata), 8'h00);
    n_rst = 1'b1;
    ready_en = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame: A5 04 12 03 40 55
    exp_gap = 4;
    send(3'd4, 8'h12, 8'h03, 8'h40, 8'h55);
    wait_frame(200);

    // Input hold: fields change right after start
    send(3'd4, 8'h12, 8'h03, 8'h40, 8'h55);
    score = 8'hFF;
    mode = 3'd7;
    num_hits = 8'h00;
    wait_frame(200);

    // Backpressure before byte2: A5 01 12 34 56 71
    exp_gap = 0;
    s0 = strobes;
    send(3'd1, 8'h12, 8'h34, 8'h56, 8'h71);
    wait_strobes(s0 + 2, 100);
    ready_en = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_txclk_low", int'(txclk), 0);
      chk("bp_txdata_hold", int'(txdata), 8'h12);
    end
    ready_en = 1'b1;
    wait_frame(200);

    // Timeout: txready never drops, A5 02 AA 0F 33 94
    auto_drop = 1'b0;
    exp_gap = 1 + STROBE_LEN + BUSY_TIMEOUT;
    send(3'd2, 8'hAA, 8'h0F, 8'h33, 8'h94);
    wait_frame(400);
    auto_drop = 1'b1;
    repeat (2) @(negedge clk);

    // Start while busy: A5 03 05 06 07 07, second start ignored
    exp_gap = 4;
    s0 = strobes;
    send(3'd3, 8'h05, 8'h06, 8'h07, 8'h07);
    wait_strobes(s0 + 4, 100);
    mode = 3'd7; num_hits = 8'hEE; num_misses = 8'hDD; score = 8'hCC;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_frame(200);
    chk("strobes_per_frame", strobes - s0, 6);
    repeat (10) @(negedge clk);
    chk("no_extra_busy", int'(busy), 0);

    // Reset during byte2 strobe, then a clean frame
    s0 = strobes;
    send(3'd5, 8'h21, 8'h43, 8'h65, 8'h02);
    wait_strobes(s0 + 3, 100);
    chk("in_strobe_before_rst", int'(txclk), 1);
    n_rst = 1'b0;
    @(negedge clk);
    chk("midrst_txclk", int'(txclk), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_txdata", int'(txdata), 8'h00);
    chk("midrst_done", int'(done), 0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_resume_after_rst", int'(busy), 0);
    send(3'd4, 8'h12, 8'h03, 8'h40, 8'h55);
    wait_frame(200);

    chk("done_total", done_cnt, frames);
    chk("queue_empty_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
